core_msg_rx: RTL

CORE_MSG_RX -- requirements
Module: core_msg_rx

---
 rtl/core_msg_rx_pkg.sv | 15 +
 rtl/core_instr_buf.sv | 44 ++++
 rtl/core_msg_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/core_msg_rx_pkg.sv
// Shared constants for the core message receiver: message width and FSM state encodings.
// No logic; imported by core_msg_rx and core_instr_buf.
// No flow control of its own.
package core_msg_rx_pkg;

  localparam int MSG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_LOAD = 2'd2,
    ST_EXEC = 2'd3
  } rx_state_e;

endpackage

// File: rtl/core_instr_buf.sv
// Instruction storage: one write port, one registered read port.
// Latency: read data valid 1 cycle after the address; writes visible to reads on the following cycle.
// Backpressure: none; the writer is responsible for bounding the write address.
module core_instr_buf
  import core_msg_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [AW-1:0]    wr_addr,
  input  logic [MSG_W-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [MSG_W-1:0] rd_dat
);

  logic [MSG_W-1:0] mem [DEPTH];
  logic [MSG_W-1:0] rd_dat_d;
  logic [MSG_W-1:0] rd_dat_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rd_dat_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receiver of scheduler task messages (R0 words + instructions); sticky overflow flags when CORE_RX_ERR_EN is defined.
// Latency: all outputs registered, 1 cycle after the qualifying strobe; instruction fetch 1 cycle.
// Backpressure: core_reading drops when the instruction buffer is full, core_ready drops while executing.
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int R0_DEPTH    = 8,
  parameter int INSTR_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MSG_W-1:0]              msg_in,
  input  logic                          core_mask_loading,
  input  logic                          r0_mask_loading,
  input  logic                          r0_loading,
  input  logic                          instr_loading,
  input  logic                          exec_done,
  input  logic [$clog2(INSTR_DEPTH)-1:0] instr_rd_addr,
  output logic [MSG_W-1:0]              instr_rd_data,
  output logic [R0_DEPTH*MSG_W-1:0]     r0_data,
  output logic                          core_reading,
  output logic                          core_ready,
  output logic [$clog2(INSTR_DEPTH):0]  instr_count,
  output logic                          start_exec,
  output logic [1:0]                    err
);

  localparam int IAW = $clog2(INSTR_DEPTH);
  localparam int RAW = $clog2(R0_DEPTH);
  localparam logic [IAW:0] INSTR_FULL = (IAW+1)'(INSTR_DEPTH);
  localparam logic [IAW:0] INSTR_ONE  = (IAW+1)'(1);
  localparam logic [RAW:0] R0_FULL    = (RAW+1)'(R0_DEPTH);
  localparam logic [RAW:0] R0_ONE     = (RAW+1)'(1);

  rx_state_e                         state_q, state_d;
  logic                              r0_sel_q, r0_sel_d;
  logic [RAW:0]                      r0_ptr_q, r0_ptr_d;
  logic [IAW:0]                      instr_count_q, instr_count_d;
  logic [R0_DEPTH-1:0][MSG_W-1:0]    r0_q, r0_d;
  logic                              start_exec_q, start_exec_d;
  logic                              core_ready_q, core_ready_d;
  logic                              core_reading_q, core_reading_d;
  logic [1:0]                        err_q, err_d;
  logic                              instr_wr_vld;
  logic                              sel_hit;
  logic                              r0_ovf;
  logic                              instr_ovf;

  assign sel_hit = msg_in[CORE_ID];

  always_comb begin
    state_d       = state_q;
    r0_sel_d      = r0_sel_q;
    r0_ptr_d      = r0_ptr_q;
    instr_count_d = instr_count_q;
    r0_d          = r0_q;
    start_exec_d  = 1'b0;
    instr_wr_vld  = 1'b0;
    r0_ovf        = 1'b0;
    instr_ovf     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (core_mask_loading && sel_hit) begin
          state_d = ST_SEL;
        end
      end

      ST_SEL, ST_LOAD: begin
        if (core_mask_loading) begin
          // A new core mask mid-task restarts loading from scratch.
          r0_ptr_d      = '0;
          instr_count_d = '0;
          r0_sel_d      = 1'b0;
          state_d       = sel_hit ? ST_SEL : ST_IDLE;
        end else begin
          if (r0_mask_loading) begin
            r0_sel_d = sel_hit;
          end
          if (r0_loading && r0_sel_q) begin
            if (r0_ptr_q == R0_FULL) begin
              r0_ovf = 1'b1;
            end else begin
              r0_d[r0_ptr_q[RAW-1:0]] = msg_in;
              r0_ptr_d                = r0_ptr_q + R0_ONE;
            end
          end
          if (instr_loading) begin
            state_d = ST_LOAD;
            if (instr_count_q == INSTR_FULL) begin
              instr_ovf = 1'b1;
            end else begin
              instr_wr_vld  = 1'b1;
              instr_count_d = instr_count_q + INSTR_ONE;
            end
          end else if (state_q == ST_LOAD) begin
            // End of the instruction burst hands the task to the core.
            state_d      = ST_EXEC;
            start_exec_d = 1'b1;
          end
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          state_d       = ST_IDLE;
          r0_ptr_d      = '0;
          instr_count_d = '0;
          r0_sel_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_ready_d   = (state_d != ST_EXEC);
    core_reading_d = (state_d != ST_EXEC) && (instr_count_d != INSTR_FULL);

`ifdef CORE_RX_ERR_EN
    err_d = err_q | {instr_ovf, r0_ovf};
`else
    err_d = 2'b00;
`endif
  end

`ifndef CORE_RX_ERR_EN
  logic unused_ovf;
  assign unused_ovf = r0_ovf ^ instr_ovf ^ err_q[0] ^ err_q[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      r0_sel_q       <= 1'b0;
      r0_ptr_q       <= '0;
      instr_count_q  <= '0;
      r0_q           <= '0;
      start_exec_q   <= 1'b0;
      core_ready_q   <= 1'b1;
      core_reading_q <= 1'b1;
      err_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      r0_sel_q       <= r0_sel_d;
      r0_ptr_q       <= r0_ptr_d;
      instr_count_q  <= instr_count_d;
      r0_q           <= r0_d;
      start_exec_q   <= start_exec_d;
      core_ready_q   <= core_ready_d;
      core_reading_q <= core_reading_d;
      err_q          <= err_d;
    end
  end

  core_instr_buf #(
    .DEPTH (INSTR_DEPTH)
  ) u_instr_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_vld  (instr_wr_vld),
    .wr_addr (instr_count_q[IAW-1:0]),
    .wr_dat  (msg_in),
    .rd_addr (instr_rd_addr),
    .rd_dat  (instr_rd_data)
  );

  assign r0_data      = r0_q;
  assign instr_count  = instr_count_q;
  assign start_exec   = start_exec_q;
  assign core_ready   = core_ready_q;
  assign core_reading = core_reading_q;
`ifdef CORE_RX_ERR_EN
  assign err          = err_q;
`else
  assign err          = 2'b00;
`endif

endmodule
